// File: rtl/instr_buffer.sv
// Instruction buffer between fetch stage 1 and decode: 16-entry circular FIFO,
// up to 4 pushes and 2 pops per cycle, with a sticky overflow flag.
module instr_buffer #(
   parameter int unsigned IB_WIDTH       = 16,
   parameter int unsigned IB_WIDTH_LOG2  = 4,
   parameter int unsigned IB_DATA_BUS_WD = 66
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_IB,
   input  logic [4*IB_DATA_BUS_WD-1:0]   if1_to_ib,
   input  logic [2:0]                    push_num,
   output logic [IB_WIDTH_LOG2:0]        can_push_size,
   output logic [2*IB_DATA_BUS_WD-1:0]   ib_to_id,
   output logic [1:0]                    ib_valid,
   input  logic [1:0]                    pop_num,
   output logic                          ib_overflow
);

   localparam int unsigned CW = IB_WIDTH_LOG2 + 1;
   localparam int unsigned PW = IB_WIDTH_LOG2;
   localparam int unsigned DW = IB_DATA_BUS_WD;

   logic [DW-1:0] r_mem [IB_WIDTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   logic [DW-1:0] w_lane [4];
   logic [CW-1:0] w_pop_ext;
   logic [CW-1:0] w_eff_pop;
   logic [CW-1:0] w_after_pop;
   logic [CW:0]   w_need;
   logic          w_push_legal;
   logic [2:0]    w_push_cnt;
   logic [PW-1:0] w_head_p1;
   logic [PW-1:0] w_slot_off [IB_WIDTH];
   logic          w_slot_we  [IB_WIDTH];

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         w_lane[k] = if1_to_ib[k*DW +: DW];
      end
   end

   // Pop is clamped to occupancy; push legality is judged after that pop.
   always_comb begin
      w_pop_ext    = CW'(pop_num);
      w_eff_pop    = (w_pop_ext > r_count) ? r_count : w_pop_ext;
      w_after_pop  = r_count - w_eff_pop;
      w_need       = (CW+1)'(w_after_pop) + (CW+1)'(push_num);
      w_push_legal = (push_num <= 3'd4) && (w_need <= (CW+1)'(IB_WIDTH));
      w_push_cnt   = w_push_legal ? push_num : 3'd0;
   end

   // Each slot picks its lane by its distance from the tail.
   always_comb begin
      for (int unsigned s = 0; s < IB_WIDTH; s++) begin
         w_slot_off[s] = PW'(s) - r_tail;
         w_slot_we[s]  = !flush_IB && (w_slot_off[s] < PW'(w_push_cnt));
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned s = 0; s < IB_WIDTH; s++) begin
         if (w_slot_we[s]) begin
            r_mem[s] <= w_lane[w_slot_off[s][1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (flush_IB) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PW'(w_eff_pop);
         r_tail  <= r_tail + PW'(w_push_cnt);
         r_count <= w_after_pop + CW'(w_push_cnt);
         if (!w_push_legal) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_head_p1     = r_head + PW'(1);
   assign ib_to_id      = {r_mem[w_head_p1], r_mem[r_head]};
   assign ib_valid      = {r_count >= CW'(2), r_count >= CW'(1)};
   assign can_push_size = r_count;
   assign ib_overflow   = r_overflow;

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer with a queue-based scoreboard of buffered entries.
module tb_instr_buffer;

   localparam int unsigned W = 66;
   typedef logic [W-1:0] ent_t;

   logic           clk;
   logic           rst;
   logic           flush_IB;
   logic [4*W-1:0] if1_to_ib;
   logic [2:0]     push_num;
   logic [4:0]     can_push_size;
   logic [2*W-1:0] ib_to_id;
   logic [1:0]     ib_valid;
   logic [1:0]     pop_num;
   logic           ib_overflow;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t sb[$];
   bit   m_ovf   = 1'b0;
   logic [31:0] next_pc = 32'h1c00_0000;

   instr_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .flush_IB      (flush_IB),
      .if1_to_ib     (if1_to_ib),
      .push_num      (push_num),
      .can_push_size (can_push_size),
      .ib_to_id      (ib_to_id),
      .ib_valid      (ib_valid),
      .pop_num       (pop_num),
      .ib_overflow   (ib_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t mk(input logic [31:0] pc);
      return {1'b1, pc[3], pc, pc ^ 32'hdead_beef};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      ent_t l0;
      ent_t l1;
      l0 = ib_to_id[W-1:0];
      l1 = ib_to_id[2*W-1:W];
      chk("count", W'(can_push_size), W'(sb.size()));
      chk("valid", W'(ib_valid), W'({sb.size() >= 2, sb.size() >= 1}));
      chk("overflow", W'(ib_overflow), W'(m_ovf));
      if (sb.size() >= 1) chk("lane0", l0, sb[0]);
      if (sb.size() >= 2) chk("lane1", l1, sb[1]);
   endtask

   // Entered and left at #1 after a rising edge; checks pre-edge state, then models the edge.
   task automatic cycle(input int pnum, input int pop, input bit flush = 1'b0);
      ent_t lanes [4];
      int   eff;
      bit   legal;
      check_outputs();
      for (int k = 0; k < 4; k++) lanes[k] = mk(next_pc + 32'(4 * k));
      if1_to_ib = {lanes[3], lanes[2], lanes[1], lanes[0]};
      push_num  = 3'(pnum);
      pop_num   = 2'(pop);
      flush_IB  = flush;
      @(posedge clk);
      #1;
      if (flush) begin
         sb.delete();
      end else begin
         eff   = (pop > sb.size()) ? sb.size() : pop;
         legal = (pnum <= 4) && (sb.size() - eff + pnum <= 16);
         for (int i = 0; i < eff; i++) void'(sb.pop_front());
         if (legal) begin
            for (int k = 0; k < pnum; k++) sb.push_back(lanes[k]);
            next_pc = next_pc + 32'(4 * pnum);
         end else begin
            m_ovf = 1'b1;
         end
      end
      push_num = 3'd0;
      pop_num  = 2'd0;
      flush_IB = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      flush_IB  = 1'b0;
      push_num  = 3'd0;
      pop_num   = 2'd0;
      if1_to_ib = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Idle after reset.
      repeat (10) cycle(0, 0);

      // Push four, then drain two per cycle.
      cycle(4, 0);
      chk("first_pc0", W'(ib_to_id[63:32]), W'(32'h1c00_0000));
      chk("first_pc1", W'(ib_to_id[W+63:W+32]), W'(32'h1c00_0004));
      cycle(0, 2);
      cycle(0, 2);

      // Fill to 15, advance head to slot 14, then stream across the wrap.
      cycle(4, 0);
      cycle(4, 0);
      cycle(4, 0);
      cycle(3, 0);
      repeat (5) cycle(0, 2);
      for (int i = 0; i < 40; i++) begin
         cycle((sb.size() + 4 < 16) ? 4 : 0, 2);
         chk("count_le15", W'(can_push_size <= 5'd15), W'(1));
      end

      // Illegal push at 14 entries.
      for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(0, 2);
      cycle(4, 0);
      cycle(4, 0);
      cycle(4, 0);
      cycle(2, 0);
      cycle(3, 0);
      cycle(0, 2);
      cycle(2, 1);
      cycle(0, 0);

      // Flush at six entries overrides push and pop; pop clamp afterwards.
      for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(0, 2);
      cycle(4, 0);
      cycle(2, 0);
      cycle(4, 2, 1'b1);
      cycle(1, 0);
      cycle(0, 2);
      cycle(4, 0);

      // Asynchronous reset mid-cycle clears outputs before the next edge.
      check_outputs();
      #2;
      rst = 1'b0;
      #1;
      sb.delete();
      m_ovf = 1'b0;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle(2, 0);
      cycle(0, 1);
      cycle(0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- 16-entry circular FIFO between fetch stage 1 and decode.
- Accepts 0-4 packed instruction entries per cycle from fetch stage 1 and presents up to 2 oldest entries per cycle to decode.
- Decode pops 0-2 entries per cycle.
- Exports its occupancy so fetch stage 1 can compute push credit.

Parameters:
IB_WIDTH, 16, FIFO depth in entries; power of two.
IB_WIDTH_LOG2, 4, log2(IB_WIDTH).
IB_DATA_BUS_WD, 66, entry width: {pc_valid[65], is_jump[64], pc[63:32], instr[31:0]}.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
flush_IB  input  1  synchronous flush; empties the FIFO.
if1_to_ib  input  4*IB_DATA_BUS_WD  push lanes; lane k = bits [(k+1)*W-1 : k*W]; lane 0 is oldest.
push_num  input  3  number of lanes to write this cycle, 0-4; lanes 0..push_num-1 are taken.
can_push_size  output  IB_WIDTH_LOG2+1  registered occupancy count, 0-16.
ib_to_id  output  2*IB_DATA_BUS_WD  lane 0 = oldest entry, lane 1 = next oldest.
ib_valid  output  2  bit k set when output lane k holds a real entry.
pop_num  input  2  entries consumed by decode this cycle, 0-2.
ib_overflow  output  1  sticky error flag; set on an illegal push.

Behaviour:
- State:
  - head and tail pointers, IB_WIDTH_LOG2 bits each, wrapping modulo IB_WIDTH.
  - count, IB_WIDTH_LOG2+1 bits.
  - storage array of IB_WIDTH x IB_DATA_BUS_WD.
- Reset (rst low, asynchronous):
  - head=0, tail=0, count=0, ib_overflow=0.
  - Therefore can_push_size=0 and ib_valid=2'b00.
  - ib_to_id is don't-care but must not be X-propagating into valid.
  - Storage contents are not reset.
- Flush (flush_IB high at posedge, rst high): head=tail=count=0. Any push and pop in that cycle are ignored. ib_overflow is kept.
- can_push_size = count, a direct register output.
  - No same-cycle pop credit.
  - Fetch stage 1 pushes only when count+push_num < IB_WIDTH, so it never fills the last slot. The usable depth seen by fetch is IB_WIDTH-1 = 15.
- Pop:
  - eff_pop = min(pop_num, count).
  - A pop_num greater than count is clamped silently; it is not an error.
  - Pop uses pre-push contents only. A pushed entry is never visible on ib_to_id in the cycle it is written.
- Push:
  - Legal when count - eff_pop + push_num <= IB_WIDTH.
  - If legal: lane k writes slot (tail+k) mod IB_WIDTH for k < push_num, and tail += push_num.
  - If illegal: no write, tail unchanged, ib_overflow set to 1 and held until reset.
  - push_num values 5-7 are illegal and are treated as overflow.
- Update: next count = count - eff_pop + (legal ? push_num : 0); head += eff_pop.
- Outputs (combinational from registered state, zero-cycle read):
  - ib_to_id lane 0 = mem[head]; lane 1 = mem[head+1 mod IB_WIDTH].
  - ib_valid[0] = (count >= 1); ib_valid[1] = (count >= 2).
  - pc_valid bits inside entries pass through unmodified. Decode interprets them; the FIFO treats entries as opaque.
- Wrap-around: a push of 4 with tail=14 writes slots 14, 15, 0, 1. Output lane 1 with head=15 reads slot 0.
- Latency: an entry pushed at edge N is visible at ib_to_id after edge N, i.e. 1 cycle minimum from push to decode.
- Simultaneous pop 2 and push 4 at count=2: both complete, count becomes 4.
- Reset mid-operation takes effect immediately and asynchronously. It overrides flush, push and pop.

Test Plan:
- Reset release, no traffic -> can_push_size=0, ib_valid=00, ib_overflow=0 for 10 cycles.
- Push 4 entries (pc 0x1c000000..0x1c00000c), pop_num=0 -> next cycle: can_push_size=4, ib_valid=11, lane0 pc=0x1c000000, lane1 pc=0x1c000004.
- Then pop_num=2 each cycle, no push -> two cycles later count=0, entries emerge in pc order, ib_valid=00.
- Fill to 15 in 4-wide pushes, advance head to 14 via pops, then continue push 4 / pop 2 for 40 cycles -> no loss or duplication across the slot 15->0 wrap, and count never exceeds 15 under a credit-obeying driver.
- At count=14 with pop_num=0, force push_num=3 -> no write, count stays 14, ib_overflow=1 and stays 1 after later legal traffic.
- With count=6, assert flush_IB together with push_num=4 and pop_num=2 -> next cycle count=0, ib_valid=00. Then drop rst low mid-cycle -> outputs clear before the next clock edge.
